tcdm_bank_arbiter: RTL



---
 rtl/tcdm_bank_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tcdm_bank_arbiter.sv
// Shares one TCDM SRAM bank among NumReq requesters. Grants round-robin, with an
// optional local-core priority, and routes each response to the requester that issued it.
module tcdm_bank_arbiter_checker #(
   parameter int unsigned NumReq     = 2,
   parameter int unsigned MemLatency = 1
) (
   input logic              clk_i,
   input logic              rst_ni,
   input logic [NumReq-1:0] req_i,
   input logic [NumReq-1:0] gnt_i,
   input logic [NumReq-1:0] rvalid_i
);

   a_params: assert property (@(posedge clk_i)
      (MemLatency >= 32'd1) && (MemLatency <= 32'd3) && (NumReq >= 32'd2));

   a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt_i));

   a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(rvalid_i));

   a_gnt_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (gnt_i & ~req_i) == '0);

endmodule

module tcdm_bank_arbiter #(
   parameter int unsigned NumReq     = 2,
   parameter int unsigned AddrWidth  = 10,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned BeWidth    = DataWidth / 8,
   parameter int unsigned MemLatency = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          local_prio_i,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq*AddrWidth-1:0]   addr_i,
   input  logic [NumReq-1:0]             wen_i,
   input  logic [NumReq*DataWidth-1:0]   wdata_i,
   input  logic [NumReq*BeWidth-1:0]     be_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             rvalid_o,
   output logic [DataWidth-1:0]          rdata_o,
   output logic                          mem_req_o,
   output logic [AddrWidth-1:0]          mem_addr_o,
   output logic                          mem_wen_o,
   output logic [DataWidth-1:0]          mem_wdata_o,
   output logic [BeWidth-1:0]            mem_be_o,
   input  logic [DataWidth-1:0]          mem_rdata_i
);

   localparam int unsigned IdxW = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1;
   typedef logic [IdxW-1:0] idx_t;
   localparam idx_t LastIdx = idx_t'(NumReq - 32'd1);

   function automatic logic [NumReq-1:0] idx_to_onehot(input idx_t idx);
      logic [NumReq-1:0] oh;
      for (int i = 0; i < NumReq; i++) begin
         oh[i] = (idx == idx_t'(i));
      end
      return oh;
   endfunction

   idx_t                  rr_q, rr_d;
   idx_t                  win_hi_s, win_lo_s, winner_s;
   logic                  hit_hi_s;
   logic                  any_req_s;
   logic [MemLatency-1:0] valid_q, valid_d;
   idx_t                  idx_q [MemLatency];
   idx_t                  idx_d [MemLatency];

   // Round-robin scan: lowest request at or above rr_q, else lowest below it.
   always_comb begin
      win_hi_s = '0;
      win_lo_s = '0;
      hit_hi_s = 1'b0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         win_hi_s = (req_i[i] && (idx_t'(i) >= rr_q)) ? idx_t'(i) : win_hi_s;
         hit_hi_s = (req_i[i] && (idx_t'(i) >= rr_q)) ? 1'b1 : hit_hi_s;
         win_lo_s = (req_i[i] && (idx_t'(i) < rr_q)) ? idx_t'(i) : win_lo_s;
      end
   end

   // Winner, grant vector and next round-robin pointer.
   always_comb begin
      any_req_s = |req_i;
      if (local_prio_i && req_i[0]) begin
         winner_s = '0;
      end else if (hit_hi_s) begin
         winner_s = win_hi_s;
      end else begin
         winner_s = win_lo_s;
      end

      if (any_req_s) begin
         gnt_o = idx_to_onehot(winner_s);
      end else begin
         gnt_o = '0;
      end

      if (!any_req_s) begin
         rr_d = rr_q;
      end else if (winner_s == LastIdx) begin
         rr_d = '0;
      end else begin
         rr_d = winner_s + idx_t'(1);
      end
   end

   // Bank-side request mux; with no request the winner defaults to index 0.
   always_comb begin
      mem_req_o   = any_req_s;
      mem_addr_o  = addr_i[winner_s*AddrWidth +: AddrWidth];
      mem_wen_o   = wen_i[winner_s];
      mem_wdata_o = wdata_i[winner_s*DataWidth +: DataWidth];
      mem_be_o    = be_i[winner_s*BeWidth +: BeWidth];
   end

   // Response pipeline: one {valid, requester} slot per cycle of bank latency.
   always_comb begin
      valid_d[0] = any_req_s;
      idx_d[0]   = winner_s;
      for (int s = 1; s < MemLatency; s++) begin
         valid_d[s] = valid_q[s-1];
         idx_d[s]   = idx_q[s-1];
      end
   end

   // Output stage of the response pipeline; read data passes straight through.
   always_comb begin
      rdata_o = mem_rdata_i;
      if (valid_q[MemLatency-1]) begin
         rvalid_o = idx_to_onehot(idx_q[MemLatency-1]);
      end else begin
         rvalid_o = '0;
      end
   end

   // Arbiter pointer and response pipeline state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q    <= '0;
         valid_q <= '0;
         for (int s = 0; s < MemLatency; s++) begin
            idx_q[s] <= '0;
         end
      end else begin
         rr_q    <= rr_d;
         valid_q <= valid_d;
         for (int s = 0; s < MemLatency; s++) begin
            idx_q[s] <= idx_d[s];
         end
      end
   end

   tcdm_bank_arbiter_checker #(
      .NumReq     (NumReq),
      .MemLatency (MemLatency)
   ) u_checker (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .gnt_i    (gnt_o),
      .rvalid_i (rvalid_o)
   );

endmodule
